// File: rtl/seq_detect_param.sv
// seq_detect_param: programmable serial pattern detector (1..MAX_LEN bits) with
// run-time overlap selection, registered match pulse and saturating match counter.
// Ports:
//   CLK        clock, rising edge
//   RESET      asynchronous active-low reset
//   IN, EN     serial bit and its sample qualifier
//   LOAD       latch PATTERN/LEN/OVERLAP and clear history (IN discarded)
//   PATTERN    pattern, PATTERN[LEN-1] received first, PATTERN[0] last
//   LEN        pattern length
//   OVERLAP    1 = overlapping matches allowed
//   CLR_CNT    synchronous clear of MATCH_CNT (a same-edge match then counts 1)
//   OUT        one-cycle registered match pulse
//   MATCH_CNT  saturating match count
//   CFG_ERR    latched LEN is 0 or above MAX_LEN
module seq_detect_param #(
   parameter int                 MAX_LEN     = 8,
   parameter int                 LEN_W       = 4,
   parameter int                 CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'('b1010),
   parameter logic [LEN_W-1:0]   RST_LEN     = LEN_W'(4),
   parameter logic               RST_OVERLAP = 1'b1
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               IN,
   input  logic               EN,
   input  logic               LOAD,
   input  logic [MAX_LEN-1:0] PATTERN,
   input  logic [LEN_W-1:0]   LEN,
   input  logic               OVERLAP,
   input  logic               CLR_CNT,
   output logic               OUT,
   output logic [CNT_W-1:0]   MATCH_CNT,
   output logic               CFG_ERR
);
   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
   // The oldest history bit is shifted out before it can ever be compared,
   // so only MAX_LEN-1 bits are stored; IN completes the compare window.
   logic [MAX_LEN-2:0] hist;
   logic [MAX_LEN-1:0] hist_nxt, cfg_pat, mask;
   logic [LEN_W-1:0]   fill, fill_nxt, cfg_len;
   logic [CNT_W-1:0]   cnt_base;
   logic               cfg_ovl, match;
   for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
      assign mask[i] = cfg_len > LEN_W'(i);
   end
   always_comb begin
      hist_nxt = {hist, IN};
      fill_nxt = fill == MAX_L ? fill : fill + LEN_W'(1);
      match    = EN && !LOAD && !CFG_ERR && fill_nxt >= cfg_len &&
                 ((hist_nxt ^ cfg_pat) & mask) == '0;
      cnt_base = CLR_CNT ? '0 : MATCH_CNT;
   end
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         hist      <= '0;
         fill      <= '0;
         cfg_pat   <= RST_PATTERN;
         cfg_len   <= RST_LEN;
         cfg_ovl   <= RST_OVERLAP;
         CFG_ERR   <= (RST_LEN == '0) || (RST_LEN > MAX_L);
         OUT       <= 1'b0;
         MATCH_CNT <= '0;
      end else begin
         OUT       <= match;
         MATCH_CNT <= match && !(&cnt_base) ? cnt_base + CNT_W'(1) : cnt_base;
         if (LOAD) begin
            cfg_pat <= PATTERN;
            cfg_len <= LEN;
            cfg_ovl <= OVERLAP;
            CFG_ERR <= (LEN == '0) || (LEN > MAX_L);
            hist    <= '0;
            fill    <= '0;
         end else if (EN) begin
            hist <= hist_nxt[MAX_LEN-2:0];
            // Non-overlap: forget the matched bits so none can start a new match.
            fill <= match && !cfg_ovl ? '0 : fill_nxt;
         end
      end
   end
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed bench for seq_detect_param with a queue-based
// reference model checked every cycle, plus literal per-step expectations.
// Two instances share all inputs: default counter width and a 2-bit counter.
module tb_seq_detect_param;
   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       IN = 1'b0, EN = 1'b0, LOAD = 1'b0, OVERLAP = 1'b0, CLR_CNT = 1'b0;
   logic [7:0] PATTERN = '0;
   logic [3:0] LEN = '0;
   logic       out_a, err_a, out_b, err_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;
   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   seq_detect_param u_dut (
      .CLK(CLK), .RESET(RESET), .IN(IN), .EN(EN), .LOAD(LOAD), .PATTERN(PATTERN),
      .LEN(LEN), .OVERLAP(OVERLAP), .CLR_CNT(CLR_CNT),
      .OUT(out_a), .MATCH_CNT(cnt_a), .CFG_ERR(err_a)
   );
   seq_detect_param #(.CNT_W(2)) u_sat (
      .CLK(CLK), .RESET(RESET), .IN(IN), .EN(EN), .LOAD(LOAD), .PATTERN(PATTERN),
      .LEN(LEN), .OVERLAP(OVERLAP), .CLR_CNT(CLR_CNT),
      .OUT(out_b), .MATCH_CNT(cnt_b), .CFG_ERR(err_b)
   );

   // Reference model: the bits received since the last clear, newest at the back.
   bit   q[$];
   logic [7:0] m_pat = 8'b1010;
   int   m_len = 4;
   bit   m_ovl = 1'b1, m_err = 1'b0, m_out = 1'b0;
   int   m_c8 = 0, m_c2 = 0;

   task automatic model_step();
      bit hit;
      int n;
      hit = 1'b0;
      if (!RESET) begin
         q.delete();
         m_pat = 8'b1010; m_len = 4; m_ovl = 1'b1; m_err = 1'b0;
         m_out = 1'b0; m_c8 = 0; m_c2 = 0;
      end else begin
         if (LOAD) begin
            m_pat = PATTERN; m_len = int'(LEN); m_ovl = OVERLAP;
            m_err = (LEN == 0) || (LEN > 8);
            q.delete();
         end else if (EN) begin
            q.push_back(IN);
            if (q.size() > 8) void'(q.pop_front());
            n = q.size();
            if (!m_err && n >= m_len) begin
               hit = 1'b1;
               for (int k = 0; k < m_len; k++)
                  if (q[n - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
            end
            if (hit && !m_ovl) q.delete();
         end
         if (CLR_CNT) begin m_c8 = 0; m_c2 = 0; end
         if (hit) begin
            if (m_c8 < 255) m_c8++;
            if (m_c2 < 3) m_c2++;
         end
         m_out = hit;
      end
   endtask

   always @(posedge CLK or negedge RESET) model_step();

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      chk("model_out", {31'd0, out_a}, {31'd0, m_out});
      chk("model_out_sat", {31'd0, out_b}, {31'd0, m_out});
      chk("model_cnt", {24'd0, cnt_a}, m_c8);
      chk("model_cnt_sat", {30'd0, cnt_b}, m_c2);
      chk("model_err", {31'd0, err_a}, {31'd0, m_err});
      chk("model_err_sat", {31'd0, err_b}, {31'd0, m_err});
   end

   task automatic step(input logic b, input logic e, input logic exp, input string nm);
      @(negedge CLK);
      IN = b; EN = e; LOAD = 1'b0; CLR_CNT = 1'b0;
      @(posedge CLK);
      #1 chk(nm, {31'd0, out_a}, {31'd0, exp});
   endtask

   task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o,
                       input logic b, input logic e, input logic exp_err);
      @(negedge CLK);
      PATTERN = p; LEN = l; OVERLAP = o; IN = b; EN = e; LOAD = 1'b1; CLR_CNT = 1'b0;
      @(posedge CLK);
      #1 chk("load_out", {31'd0, out_a}, 0);
      chk("load_err", {31'd0, err_a}, {31'd0, exp_err});
   endtask

   task automatic clr();
      @(negedge CLK);
      EN = 1'b0; LOAD = 1'b0; CLR_CNT = 1'b1;
      @(posedge CLK);
      #1 chk("clr_cnt", {24'd0, cnt_a}, 0);
   endtask

   initial begin
      logic [7:0] v;
      #1 RESET = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK) RESET = 1'b1;
      #1 chk("rst_out", {31'd0, out_a}, 0);
      chk("rst_cnt", {24'd0, cnt_a}, 0);
      chk("rst_err", {31'd0, err_a}, 0);

      // Reset defaults: 1010 overlapping
      step(1, 1, 0, "t1_b1"); step(0, 1, 0, "t1_b2"); step(1, 1, 0, "t1_b3");
      step(0, 1, 1, "t1_b4"); step(1, 1, 0, "t1_b5"); step(0, 1, 1, "t1_b6");
      chk("t1_cnt", {24'd0, cnt_a}, 2);

      // Non-overlap 1010
      clr();
      load(8'b1010, 4, 0, 0, 0, 0);
      v = 8'b10101010;
      for (int i = 7; i >= 0; i--)
         step(v[i], 1, (i == 4) || (i == 0), "t2_bit");
      chk("t2_cnt", {24'd0, cnt_a}, 2);

      // Length 8 with an idle cycle after every bit
      clr();
      load(8'hA5, 8, 1, 0, 0, 0);
      v = 8'hA5;
      for (int i = 7; i >= 0; i--) begin
         step(v[i], 1, i == 0, "t3_bit");
         step(~v[i], 0, 0, "t3_gap");
      end
      chk("t3_cnt", {24'd0, cnt_a}, 1);

      // Invalid configurations
      load(8'h00, 0, 1, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(i[0], 1, 0, "t4_len0");
      load(8'hFF, 9, 1, 0, 0, 1);
      for (int i = 0; i < 10; i++) step(1, 1, 0, "t4_len9");
      chk("t4_cnt", {24'd0, cnt_a}, 1);

      // LOAD with EN=1 discards IN; saturation on 2-bit counter; clear+match
      clr();
      load(8'h01, 1, 1, 1, 1, 0);
      for (int i = 0; i < 5; i++) step(1, 1, 1, "t5_one");
      chk("t5_cnt", {24'd0, cnt_a}, 5);
      chk("t5_sat", {30'd0, cnt_b}, 3);
      @(negedge CLK);
      IN = 1'b1; EN = 1'b1; CLR_CNT = 1'b1;
      @(posedge CLK);
      #1 chk("t5_clr_out", {31'd0, out_a}, 1);
      chk("t5_clr_cnt", {24'd0, cnt_a}, 1);
      chk("t5_clr_sat", {30'd0, cnt_b}, 1);

      // Async reset mid-pattern while OUT is high
      load(8'b101, 3, 1, 0, 0, 0);
      step(1, 1, 0, "t6_b1"); step(0, 1, 0, "t6_b2"); step(1, 1, 1, "t6_b3");
      @(negedge CLK);
      EN = 1'b0;
      #2 RESET = 1'b0;
      #1 chk("t6_rst_out", {31'd0, out_a}, 0);
      chk("t6_rst_cnt", {24'd0, cnt_a}, 0);
      chk("t6_rst_sat", {30'd0, cnt_b}, 0);
      @(posedge CLK);
      @(negedge CLK) RESET = 1'b1;
      step(0, 1, 0, "t6_after");
      chk("t6_err", {31'd0, err_a}, 0);
      step(0, 0, 0, "t6_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
